// File: rtl/wb_burst_checker.sv
// wb_burst_checker: Wishbone B3 burst master that writes a keyed pattern, reads it back and counts mismatching beats.
module wb_burst_checker #(
   parameter int ADR_W = 32,
   parameter logic [ADR_W-1:0] BASE_ADR = '0,
   parameter int NR_OF_BURSTS = 16,
   parameter int BURST_LEN = 4,
   parameter int BURST_MODE = 1,
   parameter logic [31:0] SEED = 32'hA5A5_0000,
   parameter int TIMEOUT = 1024
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic             start,
   output logic [ADR_W-1:0] wb_adr_o,
   output logic [31:0]      wb_dat_o,
   output logic [3:0]       wb_sel_o,
   output logic             wb_we_o,
   output logic [2:0]       wb_cti_o,
   output logic [1:0]       wb_bte_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   output logic             busy,
   output logic             done,
   output logic             ok,
   output logic             timeout,
   output logic [15:0]      err_cnt
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [8:0] LAST_K = 9'(BURST_LEN - 1);
   localparam logic [15:0] LAST_B = 16'(NR_OF_BURSTS - 1);
   localparam bit WRAP = BURST_MODE >= 2;
   localparam bit CLASSIC = BURST_MODE == 0;
   localparam logic [1:0] BTE = WRAP ? 2'(BURST_MODE - 1) : 2'b00;
   localparam logic [2:0] CTI0 = CLASSIC ? 3'b000 : (BURST_LEN == 1 ? 3'b111 : 3'b010);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_GAP, S_RD, S_RD_GAP, S_DONE} state_t;

   state_t           r_state;
   logic [15:0]      r_b;
   logic [8:0]       r_k;
   logic [WD_W-1:0]  r_wd;
   logic [ADR_W-1:0] r_adr;
   logic [31:0]      r_dat;
   logic [2:0]       r_cti;
   logic [1:0]       r_bte;
   logic [3:0]       r_sel;
   logic             r_we, r_cyc, r_stb, r_busy, r_done, r_to;
   logic [15:0]      r_err;

   logic             w_last_k, w_last_b, w_end;
   logic [15:0]      w_nb;
   logic [8:0]       w_nk, w_off;
   logic [ADR_W-1:0] w_adr;
   logic [31:0]      w_dat;
   logic [2:0]       w_cti;

   // Next beat to present after an ack; the final beat of a phase rewinds to burst 0, beat 0.
   always_comb begin
      w_last_k = r_k == LAST_K;
      w_last_b = r_b == LAST_B;
      w_end = w_last_k & w_last_b;
      w_nb = w_last_k ? (w_last_b ? 16'd0 : r_b + 16'd1) : r_b;
      w_nk = w_last_k ? 9'd0 : r_k + 9'd1;
      w_off = WRAP ? 9'((32'(w_nb) + 32'(w_nk)) % BURST_LEN) : w_nk;
      w_adr = BASE_ADR + ADR_W'(32'(w_nb) * BURST_LEN * 4) + ADR_W'({w_off, 2'b00});
      w_dat = 32'(w_adr) ^ SEED ^ {16'h0, w_nb};
      w_cti = CLASSIC ? 3'b000 : (w_nk == LAST_K ? 3'b111 : 3'b010);
   end

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         r_state <= S_IDLE;
         r_b <= '0;
         r_k <= '0;
         r_wd <= '0;
         r_adr <= '0;
         r_dat <= '0;
         r_cti <= '0;
         r_bte <= '0;
         r_sel <= '0;
         r_we <= 1'b0;
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_to <= 1'b0;
         r_err <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (start) begin
               r_state <= S_WR;
               r_b <= '0;
               r_k <= '0;
               r_wd <= '0;
               r_adr <= BASE_ADR;
               r_dat <= 32'(BASE_ADR) ^ SEED;
               r_cti <= CTI0;
               r_bte <= BTE;
               r_sel <= 4'hF;
               r_we <= 1'b1;
               r_cyc <= 1'b1;
               r_stb <= 1'b1;
               r_busy <= 1'b1;
               r_done <= 1'b0;
               r_to <= 1'b0;
               r_err <= '0;
            end
            S_WR, S_RD: if (wb_ack_i) begin
               r_wd <= '0;
               r_b <= w_nb;
               r_k <= w_nk;
               r_adr <= w_adr;
               r_dat <= w_dat;
               r_cti <= w_cti;
               if (r_state == S_RD && wb_dat_i != r_dat && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
               if (w_end) begin
                  r_cyc <= 1'b0;
                  r_stb <= 1'b0;
                  r_we <= 1'b0;
                  r_state <= (r_state == S_WR) ? S_RD_GAP : S_DONE;
                  r_busy <= r_state == S_WR;
                  r_done <= r_state == S_RD;
               end else if (w_last_k || CLASSIC) begin
                  r_cyc <= 1'b0;
                  r_stb <= 1'b0;
                  r_state <= (r_state == S_WR) ? S_WR_GAP : S_RD_GAP;
               end
            end else if (r_wd == WD_W'(TIMEOUT)) begin
               r_to <= 1'b1;
               r_cyc <= 1'b0;
               r_stb <= 1'b0;
               r_we <= 1'b0;
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_state <= S_DONE;
            end else begin
               r_wd <= r_wd + 1'b1;
            end
            S_WR_GAP, S_RD_GAP: begin
               r_state <= (r_state == S_WR_GAP) ? S_WR : S_RD;
               r_cyc <= 1'b1;
               r_stb <= 1'b1;
               r_wd <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;
   assign wb_sel_o = r_sel;
   assign wb_we_o = r_we;
   assign wb_cti_o = r_cti;
   assign wb_bte_o = r_bte;
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign busy = r_busy;
   assign done = r_done;
   assign timeout = r_to;
   assign err_cnt = r_err;
   assign ok = r_done & ~|r_err & ~r_to;
endmodule

// File: doc/wb_burst_checker.md
# wb_burst_checker

Synthesizable, parametrised Wishbone B3 burst master and self-checker for memory-controller bring-up. It writes a deterministic pattern over a configurable number of bursts, reads the same locations back, and compares every beat. It reports pass/fail and an error count. It sits on one Wishbone port of the memory controller, in simulation or on silicon, and replaces the fixed behavioural masters with classic, incrementing and wrapping burst modes plus a bus watchdog.

## Interface

- ADR_W, 32: Wishbone byte-address width.
- BASE_ADR, 0: first byte address of the test region; must be 4-byte aligned and aligned to BURST_LEN*4.
- NR_OF_BURSTS, 16: bursts per phase, range 1..65535.
- BURST_LEN, 4: beats per burst, range 1..256. Must equal 4/8/16 when BURST_MODE is 2/3/4.
- BURST_MODE, 1: 0 classic, 1 incrementing linear, 2 wrap4, 3 wrap8, 4 wrap16.
- SEED, 32'hA5A5_0000: data pattern key.
- TIMEOUT, 1024: maximum cycles from stb high to ack.

- wb_clk  in  1  Wishbone clock; all logic on its rising edge.
- wb_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- wb_adr_o  out  ADR_W  byte address; bits [1:0] are always 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  always 4'hF.
- wb_we_o  out  1  high in the write phase.
- wb_cti_o  out  3  cycle type identifier.
- wb_bte_o  out  2  burst type extension.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  high in DONE; held until the next start.
- ok  out  1  done & (err_cnt==0) & ~timeout.
- timeout  out  1  sticky watchdog flag.
- err_cnt  out  16  count of mismatching read beats; saturates at 16'hFFFF.

## Operation

- **States:** IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
  - IDLE -start-> WR.
  - WR: last beat acked and more bursts remain -> WR_GAP; last beat acked on the final burst -> RD_GAP.
  - WR_GAP -> WR.
  - RD: last beat acked and more bursts remain -> RD_GAP; last beat acked on the final burst -> DONE.
  - RD_GAP -> RD.
  - DONE -start-> WR. A restart clears err_cnt and timeout.
- **Beat address** for burst b (0-based), beat k:
  - block = BASE_ADR + b*BURST_LEN*4.
  - Linear modes (0, 1): address = block + k*4.
  - Wrap modes: start offset s = b mod BURST_LEN. Address = block + ((s+k) mod BURST_LEN)*4.
- **Data pattern:** wb_dat_o = wb_adr_o ^ SEED ^ {16'h0, b[15:0]}. The read phase regenerates the same value for comparison; no storage is needed.
- **cti/bte encoding:**
  - Classic mode: cti 3'b000, bte 2'b00. Each beat is its own cycle, with cyc/stb low for one cycle between beats.
  - Burst modes: cti 3'b010 on every beat except the last, which is 3'b111.
  - bte: 00 for mode 1, 01 for wrap4, 10 for wrap8, 11 for wrap16.
  - BURST_LEN=1 in mode 1: the single beat uses cti 3'b111.
- **Compare:** on every read-phase ack, if wb_dat_i differs from the expected value, err_cnt increments, saturating at 16'hFFFF.
- **Watchdog:** a counter resets on each ack or gap cycle and increments while stb is high and ack is low. When it reaches TIMEOUT:
  - timeout goes to 1.
  - cyc and stb drop on the next edge.
  - the FSM goes to DONE, so ok=0.
- **Ack outside a cycle:** wb_ack_i while cyc is low is ignored.

## Timing

- **Reset values:** all outputs 0; state IDLE. Reset is asynchronous, so asserting it mid-burst drops cyc/stb immediately, without waiting for an edge.
- **Start latency:** start sampled at edge N. At edge N+1: cyc, stb, we, wb_adr_o=BASE_ADR and busy are high/valid.
- **Beat advance:** ack sampled at an edge advances adr, dat, cti and the beat counter at that same edge. A zero-wait slave (ack every cycle) therefore completes one beat per clock.
- **Hold while waiting:** outputs are held stable while ack is low.
- **Burst spacing:** exactly one cycle with cyc=0 between bursts, and between the write and read phases.
- **Minimum run length** with an always-ack slave, from start to done: 2*(NR_OF_BURSTS*(BURST_LEN+1)) + 1 cycles.
- **done timing:** done rises one edge after the final read ack. err_cnt is final in that same cycle.
- **start while busy:** ignored.

## Test plan

1. Mode 1, BURST_LEN=4, NR_OF_BURSTS=2, BASE_ADR=0x100, zero-wait RAM slave -> write addresses 0x100..0x11C with cti 010,010,010,111 per burst; 8 reads follow; done after 21 cycles; ok=1, err_cnt=0.
2. Mode 2 (wrap4), NR_OF_BURSTS=2, BASE_ADR=0 -> burst 1 addresses 0x14, 0x18, 0x1C, 0x10 with bte=01; ok=1.
3. Mode 0, NR_OF_BURSTS=3, BURST_LEN=1, slave acks after 3 wait states -> cti=000 throughout; cyc low between beats; ok=1.
4. Slave corrupts read data at address 0x104 in scenario 1 -> err_cnt=1, ok=0, done=1.
5. Slave never acks, TIMEOUT=16 -> cyc drops 17 cycles after stb rises; timeout=1, done=1, ok=0.
6. wb_rst pulsed low mid write burst, then start reapplied -> outputs zero asynchronously; the restarted run begins again at BASE_ADR and completes with ok=1.
